// File: rtl/wb_seq_pkg.sv
// Shared types for the writeback register-write sequencer.
package wb_seq_pkg;
    typedef enum logic {IDLE, DBL} wb_seq_state_t;

    localparam logic [4:0] REG_G0 = 5'd0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_seq_odd_t;
endpackage

// File: rtl/wb_regwrite_sequencer_if.sv
// Bus between writeback and the sequencer, plus the rf/Y/icc write side.
interface wb_regwrite_sequencer_if #(parameter int XLEN = 32);
    logic              in_valid;
    logic              in_ready;
    logic [2*XLEN-1:0] in_data;
    logic [4:0]        in_regD;
    logic              in_reg_en;
    logic              in_dbl_en;
    logic              in_Y_en;
    logic              in_icc_en;
    logic [3:0]        in_icc;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              Y_we;
    logic [XLEN-1:0]   Y_wdata;
    logic              icc_we;
    logic [3:0]        icc_wdata;
    logic              busy;

    modport master (
        output in_valid, in_data, in_regD, in_reg_en, in_dbl_en, in_Y_en, in_icc_en, in_icc,
        input  in_ready, rf_we, rf_waddr, rf_wdata, Y_we, Y_wdata, icc_we, icc_wdata, busy
    );

    modport slave (
        input  in_valid, in_data, in_regD, in_reg_en, in_dbl_en, in_Y_en, in_icc_en, in_icc,
        output in_ready, rf_we, rf_waddr, rf_wdata, Y_we, Y_wdata, icc_we, icc_wdata, busy
    );
endinterface

// File: rtl/wb_seq_perf_ctr.sv
// Saturating event counter, synchronous clear.
module wb_seq_perf_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    always_ff @(posedge clk) begin
        if (reset)
            o_count <= '0;
        else if (i_inc && (o_count != {W{1'b1}}))
            o_count <= o_count + 1'b1;
    end
endmodule

// File: rtl/wb_regwrite_sequencer.sv
// Splits 64-bit writeback results into one or two 32-bit register file writes.
// Optional perf counters enabled with `define WB_SEQ_PERF_EN.
module wb_regwrite_sequencer
    import wb_seq_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    wb_regwrite_sequencer_if.slave bus
`ifdef WB_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0]    perf_single,
    output logic [PERF_W-1:0]    perf_double,
    output logic [PERF_W-1:0]    perf_stall
`endif
);
    wb_seq_state_t r_state, w_state_nxt;
    wb_seq_odd_t   r_odd;
    logic          w_acc;
    logic [4:0]    w_even;

    assign w_acc  = bus.in_valid & bus.in_ready;
    assign w_even = {bus.in_regD[4:1], 1'b0};

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && bus.in_reg_en && bus.in_dbl_en)
                    w_state_nxt = DBL;
            end
            DBL: begin
                bus.busy    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Writes to r0 are squashed at the enable; address/data still update.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rf_we     <= 1'b0;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
            bus.Y_we      <= 1'b0;
            bus.Y_wdata   <= '0;
            bus.icc_we    <= 1'b0;
            bus.icc_wdata <= '0;
            r_odd         <= '0;
        end else begin
            bus.rf_we  <= 1'b0;
            bus.Y_we   <= 1'b0;
            bus.icc_we <= 1'b0;
            if (r_state == DBL) begin
                bus.rf_we    <= (r_odd.addr != REG_G0);
                bus.rf_waddr <= r_odd.addr;
                bus.rf_wdata <= r_odd.data;
            end else if (w_acc) begin
                bus.Y_we   <= bus.in_Y_en;
                bus.icc_we <= bus.in_icc_en;
                if (bus.in_Y_en)
                    bus.Y_wdata <= bus.in_data[2*XLEN-1:XLEN];
                if (bus.in_icc_en)
                    bus.icc_wdata <= bus.in_icc;
                if (bus.in_reg_en) begin
                    if (bus.in_dbl_en) begin
                        bus.rf_we    <= (w_even != REG_G0);
                        bus.rf_waddr <= w_even;
                        bus.rf_wdata <= bus.in_data[2*XLEN-1:XLEN];
                        r_odd.addr   <= {bus.in_regD[4:1], 1'b1};
                        r_odd.data   <= bus.in_data[XLEN-1:0];
                    end else begin
                        bus.rf_we    <= (bus.in_regD != REG_G0);
                        bus.rf_waddr <= bus.in_regD;
                        bus.rf_wdata <= bus.in_data[XLEN-1:0];
                    end
                end
            end
        end
    end

`ifdef WB_SEQ_PERF_EN
    wb_seq_perf_ctr #(.W(PERF_W)) u_ctr_single (
        .clk(clk), .reset(reset),
        .i_inc(w_acc & bus.in_reg_en & ~bus.in_dbl_en),
        .o_count(perf_single)
    );
    wb_seq_perf_ctr #(.W(PERF_W)) u_ctr_double (
        .clk(clk), .reset(reset),
        .i_inc(w_acc & bus.in_reg_en & bus.in_dbl_en),
        .o_count(perf_double)
    );
    wb_seq_perf_ctr #(.W(PERF_W)) u_ctr_stall (
        .clk(clk), .reset(reset),
        .i_inc(bus.in_valid & ~bus.in_ready),
        .o_count(perf_stall)
    );
`endif
endmodule

// File: tb/tb_wb_regwrite_sequencer.sv
// Directed bench for wb_regwrite_sequencer.
module tb_wb_regwrite_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wb_regwrite_sequencer_if #(.XLEN(32)) bus ();

`ifdef WB_SEQ_PERF_EN
    logic [31:0] perf_single, perf_double, perf_stall;
`endif

    wb_regwrite_sequencer #(.XLEN(32), .PERF_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef WB_SEQ_PERF_EN
        ,
        .perf_single(perf_single),
        .perf_double(perf_double),
        .perf_stall (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [4:0] rd,
                         input logic re, input logic dbl, input logic ye,
                         input logic ie, input logic [3:0] icc);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_regD   = rd;
        bus.in_reg_en = re;
        bus.in_dbl_en = dbl;
        bus.in_Y_en   = ye;
        bus.in_icc_en = ie;
        bus.in_icc    = icc;
    endtask

    task automatic idle();
        drive(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_rf_we",    bus.rf_we,    0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_Y_we",     bus.Y_we,     0);
        chk("rst_icc_we",   bus.icc_we,   0);
        reset = 1'b0;
        tick();
        chk("post_rst_rf_we",    bus.rf_we,    0);
        chk("post_rst_in_ready", bus.in_ready, 1);

        // singles, back to back
        drive(1'b1, 64'h0000_0000_DEAD_BEEF, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        chk("s5_we",   bus.rf_we,    1);
        chk("s5_addr", bus.rf_waddr, 5);
        chk("s5_data", bus.rf_wdata, 32'hDEADBEEF);
        drive(1'b1, 64'h0000_0000_CAFE_F00D, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        chk("s6_we",   bus.rf_we,    1);
        chk("s6_addr", bus.rf_waddr, 6);
        chk("s6_data", bus.rf_wdata, 32'hCAFEF00D);

        // double to r8, next transaction held during the stall
        drive(1'b1, 64'h1111_2222_3333_4444, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        chk("d8_we",    bus.rf_we,    1);
        chk("d8_addr",  bus.rf_waddr, 8);
        chk("d8_data",  bus.rf_wdata, 32'h11112222);
        chk("d8_ready", bus.in_ready, 0);
        chk("d8_busy",  bus.busy,     1);
        drive(1'b1, 64'h0000_0000_0000_00CC, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        chk("d9_we",    bus.rf_we,    1);
        chk("d9_addr",  bus.rf_waddr, 9);
        chk("d9_data",  bus.rf_wdata, 32'h33334444);
        chk("d9_ready", bus.in_ready, 1);
        chk("d9_busy",  bus.busy,     0);
        tick();
        chk("s12_we",   bus.rf_we,    1);
        chk("s12_addr", bus.rf_waddr, 12);
        chk("s12_data", bus.rf_wdata, 32'hCC);
`ifdef WB_SEQ_PERF_EN
        chk("perf_single", perf_single, 3);
        chk("perf_double", perf_double, 1);
        chk("perf_stall",  perf_stall,  1);
`endif
        idle();
        tick();
        chk("idle_we",   bus.rf_we,    0);
        chk("idle_hold", bus.rf_waddr, 12);

        // odd rd with dbl: bit 0 forced low
        drive(1'b1, 64'h7777_0000_0000_6666, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        chk("d7e_addr", bus.rf_waddr, 6);
        chk("d7e_data", bus.rf_wdata, 32'h77770000);
        idle();
        tick();
        chk("d7o_we",   bus.rf_we,    1);
        chk("d7o_addr", bus.rf_waddr, 7);
        chk("d7o_data", bus.rf_wdata, 32'h00006666);

        // r0 rule
        drive(1'b1, 64'hAAAA_AAAA_5555_5555, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        chk("d0e_we", bus.rf_we, 0);
        idle();
        tick();
        chk("d0o_we",   bus.rf_we,    1);
        chk("d0o_addr", bus.rf_waddr, 1);
        chk("d0o_data", bus.rf_wdata, 32'h55555555);
        drive(1'b1, 64'h0000_0000_0000_1234, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        chk("s0_we", bus.rf_we, 0);

        // multiply-style: rf + Y + icc in the same slot
        drive(1'b1, 64'h0000_0007_0000_0001, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100);
        tick();
        chk("mul_we",     bus.rf_we,     1);
        chk("mul_addr",   bus.rf_waddr,  3);
        chk("mul_data",   bus.rf_wdata,  1);
        chk("mul_Y_we",   bus.Y_we,      1);
        chk("mul_Y_data", bus.Y_wdata,   32'h7);
        chk("mul_icc_we", bus.icc_we,    1);
        chk("mul_icc",    bus.icc_wdata, 4'b0100);
        idle();
        tick();
        chk("mul_Y_off",   bus.Y_we,   0);
        chk("mul_icc_off", bus.icc_we, 0);

        // reset while the odd half of r10/r11 is pending
        drive(1'b1, 64'hBBBB_BBBB_CCCC_CCCC, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        tick();
        chk("d10_addr", bus.rf_waddr, 10);
        chk("d10_data", bus.rf_wdata, 32'hBBBBBBBB);
        chk("d10_Y_we", bus.Y_we,     1);
        chk("d10_busy", bus.busy,     1);
        idle();
        reset = 1'b1;
        tick();
        chk("rstd_we",    bus.rf_we,    0);
        chk("rstd_busy",  bus.busy,     0);
        chk("rstd_ready", bus.in_ready, 1);
        chk("rstd_Y_we",  bus.Y_we,     0);
        chk("rstd_addr",  bus.rf_waddr, 0);
        chk("rstd_data",  bus.rf_wdata, 0);
        reset = 1'b0;
        tick();
        chk("rstd_no_r11", bus.rf_we, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
